// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and default constants for the sprite line scheduler.
//   sched_state_t : scheduler FSM encoding (IDLE=0, SCAN=1, WAIT=2)
//   DEF_*         : default VGA timing and sprite height
//   Y_NEVER       : attribute y loaded at reset
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_SPRITE_H = 8;

  localparam logic [15:0] Y_NEVER = 16'hFFFF;

endpackage

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: sprite (x, y) attribute storage.
//   i_pix_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_we, i_wr_idx, i_wr_x/y   : single write port, takes effect on the clock edge
//   i_rd_idx, o_rd_x/y         : combinational read port (returns pre-write value
//                                on a same-cycle write to the same entry)
// Reset loads every entry with x=0, y=Y_NEVER.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int IDXW        = $clog2(NUM_SPRITES)
) (
  input  logic            i_pix_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_wr_idx,
  input  logic [15:0]     i_wr_x,
  input  logic [15:0]     i_wr_y,
  input  logic [IDXW-1:0] i_rd_idx,
  output logic [15:0]     o_rd_x,
  output logic [15:0]     o_rd_y
);

  logic [15:0] x_q [NUM_SPRITES];
  logic [15:0] y_q [NUM_SPRITES];

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= Y_NEVER;
      end
    end else if (i_we) begin
      x_q[i_wr_idx] <= i_wr_x;
      y_q[i_wr_idx] <= i_wr_y;
    end
  end

  assign o_rd_x = x_q[i_rd_idx];
  assign o_rd_y = y_q[i_rd_idx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite selection for the VGA sprite pipeline.
// During horizontal blanking of line N the attribute table is scanned, one entry
// per clock, and up to SLOTS sprites intersecting line N+1 are collected into a
// shadow set. The shadow set is published at horz H_TOTAL-1 and held for a line.
// Ports:
//   i_pix_clk, i_rst_n            : pixel clock, asynchronous active-low reset
//   i_horz_coord, i_vert_coord    : current raster position
//   i_attr_we/idx/x/y             : attribute table write port
//   o_slot_valid/x/row/idx        : published slots, slot 0 in the LSBs
//   o_overflow                    : more than SLOTS hits (or scan cut short)
//   o_busy                        : scan in progress
// Optional (macro SPRITE_SCHED_STATS_EN):
//   o_hit_count                   : saturating hit total of the published line
//   o_overflow_sticky             : set by an overflow publish, cleared by reset
//                                   or by a write to entry 0
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SLOTS       = 4,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int IDXW        = $clog2(NUM_SPRITES)
) (
  input  logic                 i_pix_clk,
  input  logic                 i_rst_n,
  input  logic [15:0]          i_horz_coord,
  input  logic [15:0]          i_vert_coord,
  input  logic                 i_attr_we,
  input  logic [IDXW-1:0]      i_attr_idx,
  input  logic [15:0]          i_attr_x,
  input  logic [15:0]          i_attr_y,
  output logic [SLOTS-1:0]     o_slot_valid,
  output logic [16*SLOTS-1:0]  o_slot_x,
  output logic [8*SLOTS-1:0]   o_slot_row,
  output logic [IDXW*SLOTS-1:0] o_slot_idx,
  output logic                 o_overflow,
`ifdef SPRITE_SCHED_STATS_EN
  output logic [7:0]           o_hit_count,
  output logic                 o_overflow_sticky,
`endif
  output logic                 o_busy
);

  localparam int CNTW = $clog2(SLOTS + 1);

  sched_state_t state_q, state_d;

  logic [IDXW-1:0]       ptr_q;
  logic [15:0]           target_q;
  logic [CNTW-1:0]       cnt_q;
  logic [SLOTS-1:0]      sh_valid_q;
  logic [16*SLOTS-1:0]   sh_x_q;
  logic [8*SLOTS-1:0]    sh_row_q;
  logic [IDXW*SLOTS-1:0] sh_idx_q;
  logic                  sh_ovf_q;

  logic [15:0] rd_x, rd_y, diff;
  logic        hit, last, start, publish, scanning, ovf_pub;

  sprite_attr_table #(
    .NUM_SPRITES (NUM_SPRITES),
    .IDXW        (IDXW)
  ) u_table (
    .i_pix_clk (i_pix_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_attr_we),
    .i_wr_idx  (i_attr_idx),
    .i_wr_x    (i_attr_x),
    .i_wr_y    (i_attr_y),
    .i_rd_idx  (ptr_q),
    .o_rd_x    (rd_x),
    .o_rd_y    (rd_y)
  );

  // Unsigned 16-bit wrap lets sprites straddle the top of the frame.
  assign diff     = target_q - rd_y;
  assign hit      = diff < 16'(SPRITE_H);
  assign last     = ptr_q == IDXW'(NUM_SPRITES - 1);
  assign publish  = i_horz_coord == 16'(H_TOTAL - 1);
  assign scanning = state_q == ST_SCAN;
  assign start    = (state_q == ST_IDLE) && (state_d == ST_SCAN);
  // A publish that lands mid-scan means the line was too short to finish.
  assign ovf_pub  = sh_ovf_q | scanning;
  assign o_busy   = scanning;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (publish) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_horz_coord == 16'(H_ACTIVE)) state_d = ST_SCAN;
        ST_SCAN: if (last) state_d = ST_WAIT;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q        <= '0;
      target_q     <= '0;
      cnt_q        <= '0;
      sh_valid_q   <= '0;
      sh_x_q       <= '0;
      sh_row_q     <= '0;
      sh_idx_q     <= '0;
      sh_ovf_q     <= 1'b0;
      o_slot_valid <= '0;
      o_slot_x     <= '0;
      o_slot_row   <= '0;
      o_slot_idx   <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (start) begin
        target_q   <= (i_vert_coord == 16'(V_TOTAL - 1)) ? 16'd0 : i_vert_coord + 16'd1;
        ptr_q      <= '0;
        cnt_q      <= '0;
        sh_valid_q <= '0;
        sh_x_q     <= '0;
        sh_row_q   <= '0;
        sh_idx_q   <= '0;
        sh_ovf_q   <= 1'b0;
      end else if (scanning) begin
        ptr_q <= ptr_q + IDXW'(1);
        if (hit) begin
          // Index order plus first-free-slot fill gives lower indices priority.
          if (cnt_q < CNTW'(SLOTS)) begin
            for (int s = 0; s < SLOTS; s++) begin
              if (CNTW'(s) == cnt_q) begin
                sh_valid_q[s]               <= 1'b1;
                sh_x_q[s*16 +: 16]          <= rd_x;
                sh_row_q[s*8 +: 8]          <= diff[7:0];
                sh_idx_q[s*IDXW +: IDXW]    <= ptr_q;
              end
            end
            cnt_q <= cnt_q + CNTW'(1);
          end else begin
            sh_ovf_q <= 1'b1;
          end
        end
      end
      if (publish) begin
        o_slot_valid <= sh_valid_q;
        o_slot_x     <= sh_x_q;
        o_slot_row   <= sh_row_q;
        o_slot_idx   <= sh_idx_q;
        o_overflow   <= ovf_pub;
      end
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0] sh_hits_q;

  always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_hits_q         <= '0;
      o_hit_count       <= '0;
      o_overflow_sticky <= 1'b0;
    end else begin
      if (start) begin
        sh_hits_q <= '0;
      end else if (scanning && hit && (sh_hits_q != 8'hFF)) begin
        sh_hits_q <= sh_hits_q + 8'd1;
      end
      if (publish) o_hit_count <= sh_hits_q;
      // A fresh overflow takes precedence over a same-cycle clear.
      if (publish && ovf_pub) begin
        o_overflow_sticky <= 1'b1;
      end else if (i_attr_we && (i_attr_idx == '0)) begin
        o_overflow_sticky <= 1'b0;
      end
    end
  end
`else
  // Statistics disabled: no hit counter or sticky overflow state.
`endif

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Testbench for sprite_line_scheduler: drives the blanking portion of each
// line (horz 636..799) and compares published slots against a reference
// model that applies the selection rules to the table contents seen by
// each entry's evaluation cycle.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] horz, vert;
  logic        we;
  logic [3:0]  widx;
  logic [15:0] wx, wy;
  logic [3:0]  o_slot_valid;
  logic [63:0] o_slot_x;
  logic [31:0] o_slot_row;
  logic [15:0] o_slot_idx;
  logic        o_overflow, o_busy;
`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0]  o_hit_count;
  logic        o_overflow_sticky;
`endif

  always #5 clk = ~clk;

  sprite_line_scheduler dut (
    .i_pix_clk    (clk),
    .i_rst_n      (rst_n),
    .i_horz_coord (horz),
    .i_vert_coord (vert),
    .i_attr_we    (we),
    .i_attr_idx   (widx),
    .i_attr_x     (wx),
    .i_attr_y     (wy),
    .o_slot_valid (o_slot_valid),
    .o_slot_x     (o_slot_x),
    .o_slot_row   (o_slot_row),
    .o_slot_idx   (o_slot_idx),
    .o_overflow   (o_overflow),
`ifdef SPRITE_SCHED_STATS_EN
    .o_hit_count       (o_hit_count),
    .o_overflow_sticky (o_overflow_sticky),
`endif
    .o_busy       (o_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mx [16];
  logic [15:0] my [16];
  logic [15:0] snap_x [16];
  logic [15:0] snap_y [16];
  logic [15:0] m_target;
  bit          m_idle, m_scan;
  logic [3:0]  exp_valid;
  logic [63:0] exp_x;
  logic [31:0] exp_row;
  logic [15:0] exp_idx;
  logic        exp_ovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mx[i] = 16'd0;
      my[i] = 16'hFFFF;
    end
    exp_valid = '0; exp_x = '0; exp_row = '0; exp_idx = '0; exp_ovf = 1'b0;
    m_idle = 1'b1;
    m_scan = 1'b0;
  endtask

  // Selection rule: walk sprites in index order, keep the first four hits.
  task automatic compute_exp();
    int cnt;
    logic [15:0] d;
    cnt = 0;
    exp_valid = '0; exp_x = '0; exp_row = '0; exp_idx = '0; exp_ovf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      d = m_target - snap_y[k];
      if (d < 16'd8) begin
        if (cnt < 4) begin
          exp_valid[cnt]         = 1'b1;
          exp_x[cnt*16 +: 16]    = snap_x[k];
          exp_row[cnt*8 +: 8]    = d[7:0];
          exp_idx[cnt*4 +: 4]    = 4'(k);
          cnt++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(o_slot_valid), 64'(exp_valid));
    check_eq({tag, "_x"},     o_slot_x,           exp_x);
    check_eq({tag, "_row"},   64'(o_slot_row),   64'(exp_row));
    check_eq({tag, "_idx"},   64'(o_slot_idx),   64'(exp_idx));
    check_eq({tag, "_ovf"},   64'(o_overflow),   64'(exp_ovf));
  endtask

  task automatic write_attr(input int idx, input logic [15:0] x, input logic [15:0] y);
    horz = 16'd0; vert = 16'd0;
    we = 1'b1; widx = 4'(idx); wx = x; wy = y;
    @(posedge clk);
    mx[idx] = x;
    my[idx] = y;
    #1;
    we = 1'b0;
  endtask

  // One line of blanking for line v (scan targets line v+1).
  // wr_h: horz at which an in-line write occurs (-1 none); rst_h/rel_h: reset window.
  task automatic run_line(input int v, input int wr_h, input int w_idx,
                          input logic [15:0] w_x, input logic [15:0] w_y,
                          input int rst_h, input int rel_h);
    int busy_n, busy_first;
    bit no_rst, scanned;
    busy_n = 0; busy_first = -1; no_rst = 1'b1; scanned = 1'b0;
    for (int h = 636; h < 800; h++) begin
      horz = 16'(h); vert = 16'(v);
      we = (h == wr_h); widx = 4'(w_idx); wx = w_x; wy = w_y;
      @(posedge clk);
      if (rst_n) begin
        if (h == 640 && m_idle) begin
          m_idle = 1'b0; m_scan = 1'b1; scanned = 1'b1;
          m_target = (v == 524) ? 16'd0 : 16'(v + 1);
        end
        // Entry k is evaluated on the edge at horz 641+k, before that edge's write.
        if (m_scan && h >= 641 && h <= 656) begin
          snap_x[h-641] = mx[h-641];
          snap_y[h-641] = my[h-641];
        end
        if (h == wr_h) begin
          mx[w_idx] = w_x;
          my[w_idx] = w_y;
        end
        if (h == 799) begin
          if (m_scan) compute_exp();
          m_scan = 1'b0;
          m_idle = 1'b1;
        end
      end
      #1;
      if (o_busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = h;
      end
      if (h == rst_h) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 64'(o_slot_valid), 64'd0);
        check_eq("rst_x", o_slot_x, 64'd0);
        check_eq("rst_ovf", 64'(o_overflow), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        model_reset();
        no_rst = 1'b0;
      end
      if (h == 700) check_outputs("hold");
      if (h == 799) check_outputs("pub");
      if (h == rel_h) rst_n = 1'b1;
    end
    we = 1'b0; horz = 16'd0;
    if (no_rst) begin
      check_eq("busy_cnt", 64'(busy_n), scanned ? 64'd16 : 64'd0);
      if (scanned) check_eq("busy_start", 64'(busy_first), 64'd640);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, wh;
    logic [15:0] tgt;
    rst_n = 1'b0; horz = '0; vert = '0; we = 1'b0; widx = '0; wx = '0; wy = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(o_slot_valid), 64'd0);
    check_eq("reset_idx", 64'(o_slot_idx), 64'd0);
    check_eq("reset_busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Park every sprite far below the frame.
    for (int i = 0; i < 16; i++) write_attr(i, 16'd0, 16'd1000);

    // Single sprite, first/last row, then past the end
    write_attr(3, 16'd120, 16'd100);
    run_line(99, -1, 0, 0, 0, -1, -1);
    check_eq("s3_idx", 64'(o_slot_idx[3:0]), 64'd3);
    check_eq("s3_row0", 64'(o_slot_row[7:0]), 64'd0);
    run_line(106, -1, 0, 0, 0, -1, -1);
    check_eq("s3_row7", 64'(o_slot_row[7:0]), 64'd7);
    run_line(107, -1, 0, 0, 0, -1, -1);
    check_eq("s3_gone", 64'(o_slot_valid), 64'd0);

    // Overflow and priority
    write_attr(0, 16'd10, 16'd50);
    write_attr(2, 16'd20, 16'd50);
    write_attr(5, 16'd30, 16'd50);
    write_attr(7, 16'd40, 16'd50);
    write_attr(9, 16'd50, 16'd50);
    run_line(49, -1, 0, 0, 0, -1, -1);
    check_eq("ovf_idx", 64'(o_slot_idx), 64'h7520);
    check_eq("ovf_flag", 64'(o_overflow), 64'd1);
    write_attr(0, 16'd10, 16'd300);
    run_line(49, -1, 0, 0, 0, -1, -1);
    check_eq("ovf2_idx", 64'(o_slot_idx), 64'h9752);
    check_eq("ovf2_flag", 64'(o_overflow), 64'd0);
    for (int i = 2; i < 10; i++) write_attr(i, 16'd0, 16'd1000);

    // Bottom line and wrap to line 0
    write_attr(1, 16'd77, 16'd524);
    run_line(523, -1, 0, 0, 0, -1, -1);
    check_eq("y524_valid", 64'(o_slot_valid), 64'd1);
    run_line(524, -1, 0, 0, 0, -1, -1);
    check_eq("y524_wrap", 64'(o_slot_valid), 64'd0);
    write_attr(6, 16'd88, 16'hFFFE);
    run_line(524, -1, 0, 0, 0, -1, -1);
    check_eq("fffe_row2", 64'(o_slot_row[7:0]), 64'd2);
    run_line(0, -1, 0, 0, 0, -1, -1);
    check_eq("fffe_row3", 64'(o_slot_row[7:0]), 64'd3);
    write_attr(6, 16'd0, 16'd1000);

    // Write on the cycle entry 4 is scanned: old value wins this line
    write_attr(4, 16'd33, 16'd10);
    run_line(9, 645, 4, 16'd33, 16'd200, -1, -1);
    check_eq("wr_old_idx", 64'(o_slot_idx[3:0]), 64'd4);
    check_eq("wr_old_valid", 64'(o_slot_valid), 64'd1);
    run_line(9, -1, 0, 0, 0, -1, -1);
    check_eq("wr_new_valid", 64'(o_slot_valid), 64'd0);

    // Reset at scan pointer 6, released mid-line
    run_line(20, -1, 0, 0, 0, 647, 700);
    run_line(20, -1, 0, 0, 0, -1, -1);

    // Randomized lines
    for (int n = 0; n < 30; n++) begin
      v = $urandom_range(0, 524);
      tgt = (v == 524) ? 16'd0 : 16'(v + 1);
      repeat (3) write_attr($urandom_range(0, 15), 16'($urandom_range(0, 639)),
                            16'(tgt - 16'($urandom_range(0, 11))));
      wh = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(636, 660);
      run_line(v, wh, $urandom_range(0, 15), 16'($urandom_range(0, 639)),
               16'(tgt - 16'($urandom_range(0, 11))), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler for the VGA sprite pipeline.
- Holds a sprite attribute table of (x, y) per sprite.
- During horizontal blanking of line N, scans the table and selects up to SLOTS sprites that intersect line N+1.
- Publishes per-slot x position, row offset and sprite index at line end; downstream sprite renderers and the pixel mux use these, stable for the whole next line.

Parameters:
- NUM_SPRITES, 16, attribute table entries (power of 2, ≤ H_TOTAL-H_ACTIVE-2).
- SLOTS, 4, max sprites drawn per line.
- SPRITE_H, 8, sprite height in lines (power of 2, ≤ 256).
- H_ACTIVE, 640, first blanking horizontal coordinate.
- H_TOTAL, 800, horizontal coordinates per line.
- V_TOTAL, 525, lines per frame.

Ports:
- i_pix_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_horz_coord  in  16  current horizontal coordinate
- i_vert_coord  in  16  current vertical coordinate
- i_attr_we  in  1  attribute table write strobe
- i_attr_idx  in  $clog2(NUM_SPRITES)  entry to write
- i_attr_x  in  16  sprite x
- i_attr_y  in  16  sprite y
- o_slot_valid  out  SLOTS  slot holds a sprite for the current line
- o_slot_x  out  16*SLOTS  packed x per slot (slot 0 in LSBs)
- o_slot_row  out  8*SLOTS  row within sprite (0..SPRITE_H-1)
- o_slot_idx  out  $clog2(NUM_SPRITES)*SLOTS  sprite index per slot
- o_overflow  out  1  more than SLOTS hits on the current line
- o_busy  out  1  scan in progress

Behaviour:
- Reset: all table entries x=0, y=16'hFFFF (never hit). All outputs 0; FSM in IDLE; shadow slots cleared.
- Reset asserted mid-scan aborts the scan immediately. The first scan after release starts at the next H_ACTIVE.
- FSM states: IDLE, SCAN, WAIT.
- IDLE -> SCAN when i_horz_coord == H_ACTIVE. On that edge:
  - target = (i_vert_coord == V_TOTAL-1) ? 0 : i_vert_coord+1
  - scan pointer = 0; shadow valid and hit count cleared; o_busy=1.
- SCAN evaluates one entry per clock, in index order 0..NUM_SPRITES-1:
  - diff = target - y, 16-bit unsigned wrap.
  - Hit when diff < SPRITE_H.
  - A hit with fewer than SLOTS slots filled writes shadow slot[count] = {x, diff[7:0], idx} and increments count.
  - A hit with slots full sets shadow overflow.
  - Lower index always wins.
- SCAN -> WAIT after entry NUM_SPRITES-1 is evaluated; o_busy falls on that edge. Scan latency is exactly NUM_SPRITES clocks.
- Publish on the edge where i_horz_coord == H_TOTAL-1, in any state:
  - Shadow slots and overflow copy to the outputs; unfilled slots have valid=0 and x/row/idx=0.
  - FSM -> IDLE.
- Publish reached while still in SCAN (parameter violation):
  - Publish the partial result and force o_overflow=1.
- Table writes take effect on the clock edge, in any state.
  - A write to the entry being scanned on the same cycle: the scan uses the pre-write value.
  - Writes after an entry was scanned affect the next line only.
- Outputs change only at publish; they are constant from horz H_TOTAL-1+1 through the next publish.

Optional Feature:
- Macro SPRITE_SCHED_STATS_EN.
- Defined:
  - Adds o_hit_count (8 bits): total hits on the published line, saturating at 255, published with the slots.
  - Adds o_overflow_sticky: set on any overflow publish, cleared only by reset or by a write with i_attr_we=1 and i_attr_idx=0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package sprite_pkg holds:
  - FSM state localparams (IDLE=0, SCAN=1, WAIT=2).
  - Default timing constants: H_ACTIVE, H_TOTAL, V_TOTAL.
  - SPRITE_H.
- Sub-module sprite_attr_table: register array with one write port and one combinational read port, plus reset init. The scheduler instantiates it once.

Test Plan:
- Sprite 3 at y=100; publish at line 99 end -> line 100: slot0 valid, idx=3, row=0. Line 107: row=7. Line 108: no valid slots.
- Sprites 0,2,5,7,9 all at y=50 -> line 50: slots hold idx 0,2,5,7; o_overflow=1. Move sprite 0 to y=300 -> slots hold 2,5,7,9; o_overflow=0.
- Sprite at y=524, SPRITE_H=8 -> hit on line 524 (row 0). Line 0 target after wrap: diff=0-524 wraps to a large value -> no hit.
- Sprite at y=16'hFFFE -> line 0 row 2, line 1 row 3 (wrap arithmetic).
- Write sprite 4 y=200 on the exact cycle the scan pointer=4 (old y=10) -> next line uses old value. The following line reflects y=200.
- Assert i_rst_n low at scan pointer 6, release mid-line -> outputs 0 immediately. The first valid publish occurs at the end of the next full line; o_busy is high for exactly 16 clocks starting at horz 640.
